// File: rtl/cdm16_int_ctrl.sv
// cdm16_int_ctrl: prioritising interrupt controller feeding the cdm16 core
// Ports:
//   input_clock_i  system clock, shared with the core
//   reset_i        asynchronous active-high reset
//   src_i          raw interrupt lines, asynchronous
//   en_mask_i      per-source enable (blocks selection, not edge latching)
//   iack_i         core IAck handshake
//   irq_o          interrupt request to the core
//   int_vec_o      6-bit vector, frozen while a request is outstanding
//   pending_o      edge latches for edge sources, synced level for level sources
//   busy_o         FSM not idle
module cdm16_int_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int VEC_BASE = 16,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '1
) (
  input  logic               input_clock_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] en_mask_i,
  input  logic               iack_i,
  output logic               irq_o,
  output logic [5:0]         int_vec_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               busy_o
);
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  if (NUM_SRC < 1 || NUM_SRC > 16 || VEC_BASE < 0 || VEC_BASE + NUM_SRC - 1 > 63) begin : g_bad_param
    $error("cdm16_int_ctrl: NUM_SRC/VEC_BASE out of range");
  end
  typedef enum logic [1:0] {IDLE, REQ, ACK, GAP} state_t;
  state_t state_q, state_d;
  logic [NUM_SRC-1:0] s1_q, s2_q, hist_q, pend_q, pend_d, clr, cand_m;
  logic [SW-1:0] sel_q, sel_d, cand;
  logic cand_v, irq_q, irq_d;
  logic [5:0] vec_q, vec_d;
  assign pending_o = (pend_q & EDGE_MASK) | (s2_q & ~EDGE_MASK);
  assign cand_m = pending_o & en_mask_i;
  // descending scan so the lowest set index is the one left standing
  always_comb begin
    cand = '0;
    cand_v = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (cand_m[i]) begin
        cand = SW'(i);
        cand_v = 1'b1;
      end
  end
  // retire clear is applied before the new edge so a same-cycle re-trigger survives
  assign clr = (state_q == ACK && !iack_i) ? (EDGE_MASK & (NUM_SRC'(1) << sel_q)) : '0;
  assign pend_d = (pend_q & ~clr) | (s2_q & ~hist_q & EDGE_MASK);
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    irq_d = irq_q;
    vec_d = vec_q;
    case (state_q)
      IDLE: begin
        irq_d = cand_v;
        sel_d = cand_v ? cand : sel_q;
        vec_d = cand_v ? 6'(VEC_BASE + int'(cand)) : 6'd0;
        state_d = cand_v ? REQ : IDLE;
      end
      REQ:
        if (iack_i) state_d = ACK;
        else if (!pending_o[sel_q] || !en_mask_i[sel_q]) begin
          irq_d = 1'b0;
          vec_d = 6'd0;
          state_d = IDLE;
        end
      ACK:
        if (!iack_i) begin
          irq_d = 1'b0;
          vec_d = 6'd0;
          state_d = GAP;
        end
      default: begin
        irq_d = 1'b0;
        vec_d = 6'd0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge input_clock_i or posedge reset_i)
    if (reset_i) begin
      s1_q <= '0;
      s2_q <= '0;
      hist_q <= '0;
      pend_q <= '0;
      state_q <= IDLE;
      sel_q <= '0;
      irq_q <= 1'b0;
      vec_q <= 6'd0;
    end else begin
      s1_q <= src_i;
      s2_q <= s1_q;
      hist_q <= s2_q;
      pend_q <= pend_d;
      state_q <= state_d;
      sel_q <= sel_d;
      irq_q <= irq_d;
      vec_q <= vec_d;
    end
  assign irq_o = irq_q;
  assign int_vec_o = vec_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_cdm16_int_ctrl.sv
// tb_cdm16_int_ctrl: directed vector bench for cdm16_int_ctrl
module tb_cdm16_int_ctrl;
  logic clk = 1'b0, rst;
  logic [7:0] src, en, pend;
  logic iack, irq, busy;
  logic [5:0] vec;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  cdm16_int_ctrl #(.NUM_SRC(8), .VEC_BASE(16), .EDGE_MASK(8'hEF)) dut (
    .input_clock_i(clk), .reset_i(rst), .src_i(src), .en_mask_i(en), .iack_i(iack),
    .irq_o(irq), .int_vec_o(vec), .pending_o(pend), .busy_o(busy));
  typedef struct {
    logic [7:0] src, en;
    logic iack, irq;
    logic [5:0] vec;
    logic busy;
    logic [7:0] pend;
  } vec_t;
  vec_t tv[26];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string nm, input logic i, input logic [5:0] v, input logic b, input logic [7:0] p);
    chk({nm, ".irq"}, 32'(irq), 32'(i));
    chk({nm, ".vec"}, 32'(vec), 32'(v));
    chk({nm, ".busy"}, 32'(busy), 32'(b));
    chk({nm, ".pend"}, 32'(pend), 32'(p));
  endtask
  initial begin
    tv[0]  = '{8'h08, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 8'h00};
    tv[1]  = '{8'h08, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 8'h00};
    tv[2]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 8'h08};
    tv[3]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 6'd19, 1'b1, 8'h08};
    tv[4]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 6'd19, 1'b1, 8'h08};
    tv[5]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 6'd19, 1'b1, 8'h08};
    tv[6]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b1, 8'h00};
    tv[7]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 8'h00};
    tv[8]  = '{8'h24, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 8'h00};
    tv[9]  = '{8'h24, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 8'h00};
    tv[10] = '{8'h24, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 8'h24};
    tv[11] = '{8'h24, 8'hFF, 1'b0, 1'b1, 6'd18, 1'b1, 8'h24};
    tv[12] = '{8'h25, 8'hFF, 1'b0, 1'b1, 6'd18, 1'b1, 8'h24};
    tv[13] = '{8'h25, 8'hFF, 1'b0, 1'b1, 6'd18, 1'b1, 8'h24};
    tv[14] = '{8'h25, 8'hFF, 1'b0, 1'b1, 6'd18, 1'b1, 8'h25};
    tv[15] = '{8'h25, 8'hFF, 1'b1, 1'b1, 6'd18, 1'b1, 8'h25};
    tv[16] = '{8'h25, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b1, 8'h21};
    tv[17] = '{8'h00, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 8'h21};
    tv[18] = '{8'h00, 8'hFF, 1'b0, 1'b1, 6'd16, 1'b1, 8'h21};
    tv[19] = '{8'h00, 8'hFF, 1'b1, 1'b1, 6'd16, 1'b1, 8'h21};
    tv[20] = '{8'h00, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b1, 8'h20};
    tv[21] = '{8'h00, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 8'h20};
    tv[22] = '{8'h00, 8'hFF, 1'b0, 1'b1, 6'd21, 1'b1, 8'h20};
    tv[23] = '{8'h00, 8'hFF, 1'b1, 1'b1, 6'd21, 1'b1, 8'h20};
    tv[24] = '{8'h00, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b1, 8'h00};
    tv[25] = '{8'h00, 8'hFF, 1'b0, 1'b0, 6'd0,  1'b0, 8'h00};
    rst = 1'b1; src = 8'h00; en = 8'hFF; iack = 1'b0;
    step(2);
    chk_all("reset", 1'b0, 6'd0, 1'b0, 8'h00);
    rst = 1'b0;
    // single edge, then priority without preemption
    for (int k = 0; k < 26; k++) begin
      src = tv[k].src; en = tv[k].en; iack = tv[k].iack;
      step(1);
      chk_all($sformatf("vec%0d", k), tv[k].irq, tv[k].vec, tv[k].busy, tv[k].pend);
    end
    // level source 4 withdrawn before iack
    src = 8'h10;
    step(2);
    chk_all("lvl_sync", 1'b0, 6'd0, 1'b0, 8'h10);
    step(1);
    chk_all("lvl_req", 1'b1, 6'd20, 1'b1, 8'h10);
    src = 8'h00;
    step(2);
    chk_all("wd_hold", 1'b1, 6'd20, 1'b1, 8'h00);
    step(1);
    chk_all("wd_drop", 1'b0, 6'd0, 1'b0, 8'h00);
    // masked edge stays pending until enabled
    en = 8'hFD; src = 8'h02;
    step(1);
    src = 8'h00;
    step(2);
    chk_all("mask_pend", 1'b0, 6'd0, 1'b0, 8'h02);
    step(3);
    chk_all("mask_hold", 1'b0, 6'd0, 1'b0, 8'h02);
    en = 8'hFF;
    step(1);
    chk_all("mask_en", 1'b1, 6'd17, 1'b1, 8'h02);
    iack = 1'b1; step(1);
    iack = 1'b0; step(1);
    chk_all("mask_ret", 1'b0, 6'd0, 1'b1, 8'h00);
    step(1);
    chk_all("mask_idle", 1'b0, 6'd0, 1'b0, 8'h00);
    // re-trigger landing exactly on the retire edge
    src = 8'h40; step(1);
    src = 8'h00; step(3);
    chk_all("rt_req", 1'b1, 6'd22, 1'b1, 8'h40);
    iack = 1'b1; step(1);
    src = 8'h40; step(1);
    src = 8'h00; step(1);
    chk_all("rt_ack", 1'b1, 6'd22, 1'b1, 8'h40);
    iack = 1'b0; step(1);
    chk_all("rt_retire", 1'b0, 6'd0, 1'b1, 8'h40);
    step(1);
    chk_all("rt_gap", 1'b0, 6'd0, 1'b0, 8'h40);
    step(1);
    chk_all("rt_again", 1'b1, 6'd22, 1'b1, 8'h40);
    iack = 1'b1; step(1);
    iack = 1'b0; step(2);
    chk_all("rt_done", 1'b0, 6'd0, 1'b0, 8'h00);
    // async reset while in ACK with iack held
    src = 8'h0A; step(4);
    chk_all("ar_req", 1'b1, 6'd17, 1'b1, 8'h0A);
    iack = 1'b1; step(1);
    chk_all("ar_ack", 1'b1, 6'd17, 1'b1, 8'h0A);
    #2 rst = 1'b1;
    #1;
    chk_all("ar_now", 1'b0, 6'd0, 1'b0, 8'h00);
    src = 8'h00; iack = 1'b0;
    step(1);
    rst = 1'b0;
    step(4);
    chk_all("ar_after", 1'b0, 6'd0, 1'b0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
